result_fifo: RTL

- Output buffer directly downstream of the convolution controller/datapath.
- Captures one convolved result word per MEM_STORE write command (fifo_command = 2'b10) and releases words on read commands (2'b01).
- After DONE, a drain sequencer streams the whole buffer out over a valid/ready port to the host/memory interface.

---
 rtl/result_fifo_pkg.sv | 21 ++
 rtl/result_fifo_ram_sdp.sv | 29 ++
 rtl/result_fifo.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/result_fifo_pkg.sv
// Shared definitions for the convolution result buffer: command encodings
// (also used by the controller), drain sequencer states and default sizes.
package result_fifo_pkg;

    localparam int unsigned RF_DATA_W       = 20;
    localparam int unsigned RF_DEPTH        = 256;
    localparam int unsigned RF_AF_THRESHOLD = 240;

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_RW    = 2'b11;

    typedef enum logic [1:0] {
        DRAIN_IDLE    = 2'd0,
        DRAIN_FETCH   = 2'd1,
        DRAIN_PRESENT = 2'd2,
        DRAIN_END     = 2'd3
    } drain_state_e;

endpackage

// File: rtl/result_fifo_ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old word.
module fifo_ram_sdp #(
    parameter int unsigned DATA_W = 20,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage write and registered read (read-first on address collision).
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/result_fifo.sv
// Result buffer behind the convolution datapath. Stores one word per write
// command, pops on read commands, and after DONE a drain sequencer streams
// the whole buffer out over a valid/ready port.
// Optional: define RESULT_FIFO_ALMOST_FULL_EN to add the almost_full output.
module result_fifo
    import result_fifo_pkg::*;
#(
    parameter int unsigned DATA_W       = RF_DATA_W,
    parameter int unsigned DEPTH        = RF_DEPTH,
    parameter int unsigned ADDR_W       = $clog2(DEPTH),
    parameter int unsigned AF_THRESHOLD = RF_AF_THRESHOLD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        fifo_command,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              drain_start,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              drain_busy,
    output logic              drain_done,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clear_err
`ifdef RESULT_FIFO_ALMOST_FULL_EN
    ,
    output logic              almost_full
`endif
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    drain_state_e      state_q;
    logic              out_valid_q;
    logic              busy_q;
    logic              done_q;

    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_hold_q;
    logic              overflow_q;
    logic              underflow_q;

    logic              wr_req;
    logic              rd_req;
    logic              drain_idle;
    logic              cmd_pop;
    logic              drain_pop;
    logic              pop;
    logic              push;
    logic [DATA_W-1:0] ram_rdata;

    assign wr_req     = (fifo_command == CMD_WRITE) || (fifo_command == CMD_RW);
    assign rd_req     = (fifo_command == CMD_READ)  || (fifo_command == CMD_RW);
    assign drain_idle = (state_q == DRAIN_IDLE);

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // Command reads are ignored entirely while the drain sequencer owns the read port.
    assign cmd_pop   = rd_req && !empty && drain_idle;
    assign drain_pop = (state_q == DRAIN_FETCH) && !empty;
    assign pop       = cmd_pop || drain_pop;
    assign push      = wr_req && (!full || pop);

    fifo_ram_sdp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .re_i    (pop),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    // Occupancy next state: simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointers, occupancy, read-valid pulse and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            rd_hold_q   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            end
            count_q    <= count_d;
            rd_valid_q <= cmd_pop;
            if (rd_valid_q) begin
                rd_hold_q <= ram_rdata;
            end
            if (wr_req && full && !pop) begin
                overflow_q <= 1'b1;
            end else if (clear_err) begin
                overflow_q <= 1'b0;
            end
            if (rd_req && empty && drain_idle) begin
                underflow_q <= 1'b1;
            end else if (clear_err) begin
                underflow_q <= 1'b0;
            end
        end
    end

    // The RAM output register is shared with the drain path, so the last
    // popped word is held locally once its rd_valid cycle has passed.
    assign rd_data   = rd_valid_q ? ram_rdata : rd_hold_q;
    assign rd_valid  = rd_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // Drain sequencer with registered valid/busy/done outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= DRAIN_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                DRAIN_IDLE: begin
                    if (drain_start) begin
                        busy_q  <= 1'b1;
                        state_q <= empty ? DRAIN_END : DRAIN_FETCH;
                    end
                end
                DRAIN_FETCH: begin
                    if (!empty) begin
                        state_q     <= DRAIN_PRESENT;
                        out_valid_q <= 1'b1;
                    end else begin
                        state_q <= DRAIN_END;
                    end
                end
                DRAIN_PRESENT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= empty ? DRAIN_END : DRAIN_FETCH;
                    end
                end
                DRAIN_END: begin
                    state_q <= DRAIN_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q     <= DRAIN_IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_valid_q ? ram_rdata : '0;
    assign drain_busy = busy_q;
    assign drain_done = done_q;

`ifdef RESULT_FIFO_ALMOST_FULL_EN
    assign almost_full = (count_q >= CNT_W'(AF_THRESHOLD));
`else
    logic unused_af_cfg;
    assign unused_af_cfg = (AF_THRESHOLD != 0);
`endif

endmodule
